// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift controller: accepts one request, shifts the working
// register one bit per cycle, then returns the result on a valid/ready port.
module shift_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROL} op_t;

  state_t           state;
  op_t              op;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   count;

  // One single-position step of the shift datapath.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] w, input op_t o);
    case (o)
      OP_SLL:  step = {w[WIDTH-2:0], 1'b0};
      OP_SRL:  step = {1'b0, w[WIDTH-1:1]};
      OP_SRA:  step = {w[WIDTH-1], w[WIDTH-1:1]};
      default: step = {w[WIDTH-2:0], w[WIDTH-1]};
    endcase
  endfunction

  // NOTE: every register here uses <= so all decisions see pre-edge values;
  // handshake outputs are registers, so no input reaches an output combinationally.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      op        <= OP_SLL;
      work      <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_data;
            op       <= op_t'(in_op);
            count    <= in_shamt;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (in_shamt != '0) begin
              state <= SHIFT;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_data  <= in_data;
            end
          end
        end

        SHIFT: begin
          work  <= step(work, op);
          count <= (count != '0) ? count - SHW'(1) : '0;
          if (count <= SHW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= step(work, op);
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl: latency, ops, backpressure,
// reset abort and back-to-back requests.
module tb_shift_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROL = 2'b11;

  shift_seq_ctrl #(.WIDTH(32), .SHW(5)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] data,
                        input int shamt, input logic [31:0] exp);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = data;
    in_shamt = shamt[4:0];
    cyc();
    in_valid = 1'b0;
    in_data  = 32'h5555_AAAA;
    in_shamt = 5'd7;
    in_op    = ~op;
    for (int k = 0; k < shamt; k++) begin
      check({tag, " valid_low"}, {31'd0, out_valid}, 32'd0);
      check({tag, " ready_low"}, {31'd0, in_ready}, 32'd0);
      check({tag, " busy"}, {31'd0, busy}, 32'd1);
      cyc();
    end
    check({tag, " valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, " data"}, out_data, exp);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check({tag, " idle_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, " idle_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, " data_kept"}, out_data, exp);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = SLL;
    out_ready = 1'b0;
    cyc();
    cyc();
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_data", out_data, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    cyc();

    // Worst-case latency and each op.
    run_op("sll31", SLL, 32'h0000_0001, 31, 32'h8000_0000);
    run_op("sra4",  SRA, 32'h8000_0000, 4,  32'hF800_0000);
    run_op("srl4",  SRL, 32'h8000_0000, 4,  32'h0800_0000);
    run_op("rol1",  ROL, 32'h8000_0001, 1,  32'h0000_0003);
    run_op("sll0",  SLL, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF);
    run_op("srl0",  SRL, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF);
    run_op("sra0",  SRA, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF);
    run_op("rol0",  ROL, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF);
    run_op("rol5",  ROL, 32'hF000_0001, 5,  32'h0000_003E);

    // Backpressure with in_valid held high during SHIFT and DONE.
    in_valid = 1'b1; in_op = SLL; in_data = 32'h0000_000F; in_shamt = 5'd4;
    cyc();
    in_data = 32'h1234_5678; in_shamt = 5'd3; in_op = SRL;
    repeat (4) cyc();
    for (int k = 0; k < 10; k++) begin
      check("bp valid", {31'd0, out_valid}, 32'd1);
      check("bp data", out_data, 32'h0000_00F0);
      check("bp in_ready", {31'd0, in_ready}, 32'd0);
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    check("bp release ready", {31'd0, in_ready}, 32'd1);
    check("bp release valid", {31'd0, out_valid}, 32'd0);
    check("bp release busy", {31'd0, busy}, 32'd0);
    // out_ready held high in IDLE must have no effect.
    cyc();
    check("bp idle stays", {31'd0, in_ready}, 32'd1);
    check("bp idle data", out_data, 32'h0000_00F0);
    out_ready = 1'b0;

    // Reset in the middle of a long shift drops the request.
    in_valid = 1'b1; in_op = SLL; in_data = 32'h0000_0001; in_shamt = 5'd20;
    cyc();
    in_valid = 1'b0;
    repeat (5) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("abort in_ready", {31'd0, in_ready}, 32'd1);
    check("abort out_valid", {31'd0, out_valid}, 32'd0);
    check("abort out_data", out_data, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      check("abort no result", {31'd0, out_valid}, 32'd0);
      cyc();
    end
    out_ready = 1'b0;

    // Back-to-back requests with in_valid held high and out_ready high.
    in_valid = 1'b1; in_op = SRL; in_data = 32'h0000_0100; in_shamt = 5'd8;
    out_ready = 1'b1;
    cyc();
    in_op = SLL; in_data = 32'h0000_0001; in_shamt = 5'd2;
    for (int k = 0; k < 8; k++) begin
      check("b2b first pending", {31'd0, out_valid}, 32'd0);
      check("b2b no accept", {31'd0, in_ready}, 32'd0);
      cyc();
    end
    check("b2b first valid", {31'd0, out_valid}, 32'd1);
    check("b2b first data", out_data, 32'h0000_0001);
    cyc();
    check("b2b idle ready", {31'd0, in_ready}, 32'd1);
    check("b2b idle valid", {31'd0, out_valid}, 32'd0);
    cyc();
    in_valid = 1'b0;
    check("b2b second busy", {31'd0, busy}, 32'd1);
    check("b2b second not ready", {31'd0, in_ready}, 32'd0);
    check("b2b second pending", {31'd0, out_valid}, 32'd0);
    cyc();
    check("b2b second pending2", {31'd0, out_valid}, 32'd0);
    cyc();
    check("b2b second valid", {31'd0, out_valid}, 32'd1);
    check("b2b second data", out_data, 32'h0000_0004);
    cyc();
    check("b2b end ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Multi-cycle controller for the single-position shift datapath in the integer unit.
- Accepts one shift request, then applies one 1-bit shift per cycle to an internal working register until the shift amount is exhausted.
- Returns the result through a valid/ready handshake.
- Replaces a full barrel shifter where area matters. Sits between ALU issue logic and writeback.

Parameters:
- WIDTH, 32, data word width in bits.
- SHW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  controller can accept a request.
- in_data  input  WIDTH  operand to shift.
- in_shamt  input  SHW  shift amount, 0..WIDTH-1.
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL (rotate left).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  shifted result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (clock edge with reset=1):
  - state=IDLE; work, count and op registers cleared.
  - in_ready=1, out_valid=0, out_data=0, busy=0.
  - Reset has priority over every other event, including mid-SHIFT or DONE. Any in-flight request is dropped and no result is produced.
- States: IDLE, SHIFT, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE. busy=1 in SHIFT and DONE.
- IDLE:
  - On in_valid & in_ready at edge T: work<=in_data, op<=in_op, count<=in_shamt.
  - Next state is SHIFT if in_shamt!=0, else DONE.
  - in_data, in_shamt and in_op are sampled only at the accept edge. Later changes are ignored.
- SHIFT: each cycle performs one step on work, then count<=count-1. Step by op:
  - SLL: work<={work[W-2:0],1'b0}.
  - SRL: work<={1'b0,work[W-1:1]}.
  - SRA: work<={work[W-1],work[W-1:1]}.
  - ROL: work<={work[W-2:0],work[W-1]}.
  - When count==1 the final step is taken and the next state is DONE.
  - count never underflows; no wrap past 0.
- DONE:
  - out_data=work, held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready the next state is IDLE.
  - out_data retains its last value after the handshake until the next result.
- Latency:
  - Accept at edge T, shamt=n: out_valid first high in the cycle after edge T+n (n=0 gives the cycle after T).
  - Worst case: shamt=31, 32 cycles from accept to out_valid.
- Throughput:
  - There is no accept in DONE, even when out_ready=1.
  - Minimum request spacing is n+2 cycles: accept, n shifts, DONE, then IDLE before the next accept.
- Boundaries:
  - in_valid held high during SHIFT/DONE is not accepted and causes no side effects.
  - out_ready high outside DONE has no effect.
  - shamt=0 for every op returns in_data unchanged.
- No combinational path from in_valid to out_valid, or from out_ready to in_ready.

Test Plan:
- Reset, then SLL in_data=0x00000001 shamt=31 -> out_valid 32 cycles after accept, out_data=0x80000000; in_ready=0 and busy=1 throughout.
- SRA in_data=0x80000000 shamt=4 -> out_data=0xF8000000. SRL with the same inputs -> out_data=0x08000000. Both after 5 cycles.
- ROL in_data=0x80000001 shamt=1 -> out_data=0x00000003. Any op with shamt=0 and in_data=0xDEADBEEF -> out_data=0xDEADBEEF, out_valid on the cycle after accept.
- Backpressure: SLL 0x0000000F shamt=4, out_ready=0 for 10 cycles -> out_valid and out_data=0x000000F0 stay stable. Then raise out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-op: accept SLL shamt=20, assert reset after 5 shift cycles -> next cycle state IDLE, out_valid=0, out_data=0, in_ready=1. The dropped request never produces a result.
- Back-to-back: in_valid held high with two requests (SRL 0x100 shamt=8, then SLL 0x1 shamt=2):
  - Second request accepted only in IDLE, after the first result's handshake.
  - Results in order: 0x00000001, then 0x00000004.
